// File: rtl/ddr3_rd_pkg.sv
// Shared types and default widths for the DDR3 read/fill controllers.
// The FSM state is one-hot; the indices name the bit positions.
package ddr3_rd_pkg;

    localparam int IDLE  = 0;
    localparam int READ  = 1;
    localparam int DRAIN = 2;
    localparam int DONE  = 3;

    localparam int ADDR_W_DEF          = 23;
    localparam int BURST_SHIFT_DEF     = 3;
    localparam int CNT_W_DEF           = 24;
    localparam int MAX_OUTSTANDING_DEF = 32;
    localparam int OUT_W_DEF           = 6;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'(1 << IDLE),
        ST_READ  = 4'(1 << READ),
        ST_DRAIN = 4'(1 << DRAIN),
        ST_DONE  = 4'(1 << DONE)
    } rd_state_e;

endpackage

// File: rtl/ddr3_sync_edge.sv
// Three-flop synchroniser for an asynchronous level, with a one-cycle
// rising-edge pulse taken between the second and third stages.
module ddr3_sync_edge (
    input  logic clk,
    input  logic reset_n,
    input  logic async_in,
    output logic sync_mid,
    output logic sync_out,
    output logic rise
);

    (* ASYNC_REG = "TRUE" *) logic sync1, sync2, sync3;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
        end else begin
            sync1 <= async_in;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign sync_mid = sync2;
    assign sync_out = sync3;
    assign rise     = sync2 & ~sync3;

endmodule

// File: rtl/ddr3_rd_control_param.sv
// DDR3 read-fill controller: issues a run of burst reads to the MIG app
// interface under a credit limit and forwards returned beats to the READ FIFO.
module ddr3_rd_control_param #(
    parameter int ADDR_W          = 23,
    parameter int BURST_SHIFT     = 3,
    parameter int CNT_W           = 24,
    parameter int MAX_OUTSTANDING = 32,
    parameter int OUT_W           = 6
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          acq_enabled,
    input  logic [ADDR_W-1:0]             rd_start_addr,
    input  logic [CNT_W-1:0]              rd_burst_cnt,
    input  logic                          enable_reading,
    output logic                          reading_done,
    output logic                          busy,
    input  logic                          app_rd_data_valid,
    input  logic                          rd_app_rdy,
    output logic                          rd_app_en,
    output logic [ADDR_W+BURST_SHIFT-1:0] ddr3_rd_addr,
    input  logic                          ddr3_rd_fifo_almost_full,
    output logic                          ddr3_rd_fifo_wr_en,
    output logic                          ddr3_rd_fifo_input_tlast,
    output logic [OUT_W-1:0]              outstanding,
    output logic                          rd_error
);

    import ddr3_rd_pkg::*;

    logic              sync2, sync3, start_pulse;
    rd_state_e         state;
    logic [ADDR_W-1:0] address_gen;
    logic [CNT_W-1:0]  addr_cntr, beat_cntr;
    logic [OUT_W-1:0]  out_cnt;
    logic              err_q;
    logic              in_read, accept, ret_ok;

    ddr3_sync_edge u_sync (
        .clk      (clk),
        .reset_n  (reset_n),
        .async_in (enable_reading),
        .sync_mid (sync2),
        .sync_out (sync3),
        .rise     (start_pulse)
    );

    assign in_read = state[READ];
    assign accept  = rd_app_en & rd_app_rdy;
    // A beat only counts against the credit pool if one was actually issued.
    assign ret_ok  = app_rd_data_valid & (out_cnt != '0);

    assign rd_app_en = in_read & ~acq_enabled & (addr_cntr != '0) &
                       ~ddr3_rd_fifo_almost_full &
                       (out_cnt < OUT_W'(MAX_OUTSTANDING));

    assign ddr3_rd_fifo_wr_en       = in_read & ret_ok;
    assign ddr3_rd_fifo_input_tlast = ddr3_rd_fifo_wr_en & (beat_cntr == CNT_W'(1));

    assign ddr3_rd_addr = {address_gen, {BURST_SHIFT{1'b0}}};
    assign outstanding  = out_cnt;
    assign rd_error     = err_q;
    assign reading_done = state[DONE];
    assign busy         = state[READ] | state[DRAIN];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            address_gen <= '0;
            addr_cntr   <= '0;
            beat_cntr   <= '0;
            out_cnt     <= '0;
            err_q       <= 1'b0;
        end else begin
            if (start_pulse) begin
                address_gen <= rd_start_addr;
                addr_cntr   <= rd_burst_cnt;
            end else if (accept) begin
                address_gen <= address_gen + ADDR_W'(1);
                addr_cntr   <= addr_cntr - CNT_W'(1);
            end

            if (start_pulse)
                beat_cntr <= rd_burst_cnt;
            else if (ddr3_rd_fifo_wr_en)
                beat_cntr <= beat_cntr - CNT_W'(1);

            case ({accept, ret_ok})
                2'b10:   out_cnt <= out_cnt + OUT_W'(1);
                2'b01:   out_cnt <= out_cnt - OUT_W'(1);
                default: ;
            endcase

            if (app_rd_data_valid && out_cnt == '0)
                err_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                // sync2 is checked too so a lingering sync3 after an abort cannot restart a fill
                ST_IDLE:
                    if (sync2 && sync3)
                        state <= (beat_cntr != '0) ? ST_READ : ST_DONE;
                ST_READ:
                    if (beat_cntr == '0)
                        state <= ST_DONE;
                    else if (!sync2)
                        state <= (out_cnt != '0) ? ST_DRAIN : ST_IDLE;
                ST_DRAIN:
                    if (out_cnt == '0)
                        state <= ST_IDLE;
                ST_DONE:
                    if (!sync2)
                        state <= ST_IDLE;
                default:
                    state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/ddr3_rd_control_param.md
Name: ddr3_rd_control_param

Overview:
Parametrised successor to the single-fill DDR3 read controller, in the DDR3 user-clock domain, between the rd_fill command logic and the MIG app interface / READ FIFO.
- Generates a run of burst read addresses from a start address and burst count, and forwards returned beats to the READ FIFO with tlast on the final beat.
- Adds a configurable outstanding-read credit limit and address wrap-around.
- Adds an abort/drain path when enable drops mid-read, and a sticky error flag for unexpected returned data.

Parameters:
ADDR_W, 23, burst-address width (128-bit burst granularity)
BURST_SHIFT, 3, zero LSBs appended to form the app address
CNT_W, 24, burst-count width
MAX_OUTSTANDING, 32, max accepted-but-unreturned reads (>=1)
OUT_W, 6, outstanding counter width, must satisfy 2^OUT_W > MAX_OUTSTANDING

Ports:
clk  in  1  DDR3 user clock
reset_n  in  1  synchronous active-low reset
acq_enabled  in  1  writing active; blocks new read requests
rd_start_addr  in  ADDR_W  first burst address, sampled at start
rd_burst_cnt  in  CNT_W  bursts to read, sampled at start
enable_reading  in  1  asynchronous level; rising edge starts a fill, low aborts/clears
reading_done  out  1  level, fill complete
busy  out  1  in READ or DRAIN
app_rd_data_valid  in  1  returned beat valid
rd_app_rdy  in  1  MIG accepts address
rd_app_en  out  1  read request
ddr3_rd_addr  out  ADDR_W+BURST_SHIFT  {address_gen, BURST_SHIFT zeros}
ddr3_rd_fifo_almost_full  in  1  FIFO back-pressure
ddr3_rd_fifo_wr_en  out  1  write beat to FIFO
ddr3_rd_fifo_input_tlast  out  1  last beat of fill, qualified by wr_en
outstanding  out  OUT_W  current in-flight reads
rd_error  out  1  sticky: valid beat received while no read outstanding

Behaviour:
- Reset (reset_n=0 at a clk edge): all counters, address_gen, sync flops and rd_error cleared; state IDLE; all outputs 0.
- enable_reading passes through a 3-flop synchroniser (sync1..sync3).
  - start_pulse = sync2 & !sync3, one cycle.
  - On start_pulse: address_gen <= rd_start_addr; addr_cntr <= rd_burst_cnt; beat_cntr <= rd_burst_cnt.
- accept = rd_app_en & rd_app_rdy.
  - On accept: address_gen +1, wrapping from 2^ADDR_W-1 to 0 (natural modulo); addr_cntr -1.
- outstanding: +1 on accept, -1 on app_rd_data_valid while outstanding>0; both in the same cycle leaves it unchanged.
- app_rd_data_valid with outstanding==0 sets rd_error. The beat is not written; outstanding stays 0. rd_error clears only on reset_n.
- States:
  - IDLE: go to READ on sync3 & beat_cntr!=0; go to DONE on sync3 & beat_cntr==0 (zero-length fill).
  - READ: go to DONE when beat_cntr==0; go to DRAIN when sync2==0 and outstanding!=0; go to IDLE when sync2==0 and outstanding==0.
  - DRAIN: rd_app_en=0, returning beats discarded (no wr_en). Go to IDLE when outstanding==0.
  - DONE: hold reading_done=1. Go to IDLE when sync2==0.
- sync2==0 also forces IDLE from IDLE/DONE, but DRAIN completes first. reset_n overrides everything.
- rd_app_en = READ & !acq_enabled & addr_cntr!=0 & !almost_full & outstanding<MAX_OUTSTANDING. It is combinational from registered state.
- ddr3_rd_fifo_wr_en = READ & app_rd_data_valid & outstanding!=0 (zero latency).
- tlast = wr_en & beat_cntr==1. beat_cntr decrements on each wr_en.
- busy = READ | DRAIN.
- A start_pulse while in READ cannot occur, because enable must fall first and that aborts the fill.

Decomposition:
- Shared package ddr3_rd_pkg: one-hot state indices IDLE=0, READ=1, DRAIN=2, DONE=3; default widths.
- One sub-module, ddr3_sync_edge: 3-flop ASYNC_REG synchroniser with rising-edge pulse output. Reusable by the write controller.
- Counters and FSM stay in the top module.

Test Plan:
- start_addr=0x10, cnt=4, rdy=1, valid returned 5 cycles after each accept -> addresses 0x80, 0x88, 0x90, 0x98; 4 wr_en; tlast on 4th only; reading_done=1 after last beat; rd_error=0.
- MAX_OUTSTANDING=2, cnt=8, data returned 20 cycles late -> rd_app_en drops with outstanding=2; never exceeds 2; 8 beats total.
- start_addr=2^23-2, cnt=4 -> address_gen sequence 0x7FFFFE, 0x7FFFFF, 0x000000, 0x000001.
- cnt=10, enable_reading dropped after 5 accepts and 2 returns -> DRAIN; 3 remaining beats produce no wr_en; IDLE when outstanding=0; reading_done never set.
- acq_enabled=1 or almost_full=1 for 50 cycles mid-fill -> rd_app_en=0 throughout, then resumes; counts intact. cnt=0 -> DONE with no requests.
- app_rd_data_valid pulse in IDLE -> rd_error=1 sticky, no wr_en; reset_n=0 for one cycle mid-READ -> all outputs 0, state IDLE.
